async_fifo_wptr_ctrl: RTL

- Write-domain pointer and flag controller for the dual-clock FIFO.
- Owns the binary and Gray write pointers, gates write requests, and produces full, almost-full, occupancy and overflow status.
- Its Gray pointer output feeds the read-domain two-flop synchroniser.
- It consumes the read pointer after a two-flop sync into this domain (rq2_rptr).
- Single clock domain (write clock).

---
 rtl/async_fifo_wptr_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer and flag controller for a dual-clock FIFO.
// Keeps the binary and Gray write pointers and gates write requests.
// Computes full, almost-full, occupancy and sticky overflow from the read
// pointer, which has already been synchronised into this clock domain.
module async_fifo_wptr_ctrl #(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [PTR_WIDTH:0]   rq2_rptr,
  input  logic                 clr_overflow,
  output logic                 wr_accept,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [PTR_WIDTH:0]   wcount,
  output logic                 overflow
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AFULL_W = PW'(AFULL_THRESH);

  logic [PTR_WIDTH:0] wbin_q, wbin_d;
  logic [PTR_WIDTH:0] wptr_q, wptr_d;
  logic [PTR_WIDTH:0] wcount_q, wcount_d;
  logic               wfull_q, wfull_d;
  logic               walmost_full_q, walmost_full_d;
  logic               overflow_q, overflow_d;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] full_cmp;

  // Gray-to-binary of the synchronised read pointer: prefix XOR from the MSB.
  assign rbin[PTR_WIDTH] = rq2_rptr[PTR_WIDTH];
  genvar gi;
  generate
    for (gi = 0; gi < PTR_WIDTH; gi++) begin : g_rbin
      assign rbin[gi] = ^rq2_rptr[PTR_WIDTH:gi];
    end
  endgenerate

  // Accept decision depends only on the registered full flag.
  assign wr_accept = wr_en & ~wfull_q;

  // Next pointers, flags and occupancy; the read pointer only reaches outputs through flops.
  always_comb begin
    wbin_d         = wbin_q + {{PTR_WIDTH{1'b0}}, wr_accept};
    wptr_d         = wbin_d ^ (wbin_d >> 1);
    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
    full_cmp       = {~rq2_rptr[PTR_WIDTH:PTR_WIDTH-1], rq2_rptr[PTR_WIDTH-2:0]};
    wfull_d        = (wptr_d == full_cmp);
    wcount_d       = wbin_d - rbin;
    walmost_full_d = (wcount_d >= AFULL_W);
    // A new overflow event takes priority over a clear in the same cycle.
    overflow_d     = (overflow_q & ~clr_overflow) | (wr_en & wfull_q);
  end

  // State registers with asynchronous assertion of the active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wcount_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wcount_q       <= wcount_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      overflow_q     <= overflow_d;
    end
  end

  assign waddr        = wbin_q[PTR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wcount       = wcount_q;
  assign overflow     = overflow_q;

endmodule
